// File: rtl/multiplicador.sv
// Weighed-goods pricer: price = floor(grams * cents_per_kg / GRAMS_PER_KG), split into euros and cents.
// Sequential datapath: shift-add multiply, then two restoring divisions, with a fixed 53-cycle latency.
module multiplicador #(
  parameter int GRAMS_PER_KG   = 1000,
  parameter int CENTS_PER_EURO = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] weightInGrams,
  input  logic [11:0] centimos,
  output logic        busy,
  output logic        done,
  output logic [11:0] preco,
  output logic [11:0] precof,
  output logic [15:0] preco_total,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DIV   = 3'd2,
    SPLIT = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [16:0] DIV_KG  = 17'(GRAMS_PER_KG);
  localparam logic [16:0] DIV_CPE = 17'(CENTS_PER_EURO);

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [23:0] mcand, acc, acc_next;
  logic [11:0] mplier;
  logic [23:0] dvd, dvd_shift;
  logic [15:0] rem, rem_next, total;
  logic [16:0] trial, divisor;
  logic        qbit;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = MUL;
      MUL:     if (cnt == 5'd11) state_next = DIV;
      DIV:     if (cnt == 5'd23) state_next = SPLIT;
      SPLIT:   if (cnt == 5'd15) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shared restoring-division step; the divisor follows the phase.
  always_comb begin
    acc_next  = mplier[0] ? acc + mcand : acc;
    trial     = {rem, dvd[23]};
    divisor   = (state == SPLIT) ? DIV_CPE : DIV_KG;
    qbit      = (trial >= divisor);
    rem_next  = qbit ? 16'(trial - divisor) : trial[15:0];
    dvd_shift = {dvd[22:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      dvd         <= '0;
      rem         <= '0;
      total       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      preco       <= '0;
      precof      <= '0;
      preco_total <= '0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || state != state_next) ? 5'd0 : cnt + 5'd1;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {12'd0, weightInGrams};
            mplier <= centimos;
            acc    <= '0;
            busy   <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == 5'd11) begin
            dvd <= acc_next;
            rem <= '0;
          end
        end
        DIV: begin
          rem <= rem_next;
          dvd <= dvd_shift;
          // Quotient fits in 16 bits; park it at the top of dvd for the euro split.
          if (cnt == 5'd23) begin
            total <= dvd_shift[15:0];
            dvd   <= {dvd_shift[15:0], 8'd0};
            rem   <= '0;
          end
        end
        SPLIT: begin
          rem <= rem_next;
          dvd <= dvd_shift;
        end
        FIN: begin
          preco       <= dvd[11:0];
          precof      <= rem[11:0];
          preco_total <= total;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador.sv
// Directed bench for multiplicador: expected prices queued at start, popped and compared on done.
module tb_multiplicador;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] weight;
  logic [11:0] cents;
  logic        busy;
  logic        done;
  logic [11:0] preco;
  logic [11:0] precof;
  logic [15:0] preco_total;
  logic [2:0]  state_dbg;

  logic [39:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] hold_total = '0;

  multiplicador dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .weightInGrams(weight),
    .centimos     (cents),
    .busy         (busy),
    .done         (done),
    .preco        (preco),
    .precof       (precof),
    .preco_total  (preco_total),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input int w, input int c);
    int t;
    t = (w * c) / 1000;
    exp_q.push_back({16'(t), 12'(t / 100), 12'(t % 100)});
  endtask

  // Start is raised before an edge; that edge is cycle 0 of the run.
  task automatic start_run(input int w, input int c, input bit hold);
    @(negedge clk);
    weight = 12'(w);
    cents  = 12'(c);
    start  = 1'b1;
    push_exp(w, c);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = 0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int lat);
    logic [39:0] e;
    while (!done && cyc < 200) begin
      check("hold_total", 32'(preco_total), 32'(hold_total));
      tick();
    end
    check("latency", 32'(cyc), 32'(lat));
    check("done_high", 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("preco_total", 32'(preco_total), 32'(e[39:24]));
      check("preco", 32'(preco), 32'(e[23:12]));
      check("precof", 32'(precof), 32'(e[11:0]));
      hold_total = e[39:24];
    end
    tick();
    check("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    weight = '0;
    cents  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_total", 32'(preco_total), 32'd0);
    check("rst_preco", 32'(preco), 32'd0);
    check("rst_precof", 32'(precof), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_run(1500, 470, 1'b0);
    wait_done(53);
    check("busy_idle", 32'(busy), 32'd0);

    start_run(4095, 4095, 1'b0);
    wait_done(53);

    start_run(1000, 199, 1'b0);
    wait_done(53);
    start_run(999, 1, 1'b0);
    wait_done(53);

    // Second start mid-run with new inputs: ignored, first result unchanged.
    start_run(2000, 300, 1'b0);
    while (cyc < 10) tick();
    @(negedge clk);
    weight = 12'd4095;
    cents  = 12'd4095;
    start  = 1'b1;
    tick();
    start = 1'b0;
    wait_done(53);
    check("no_queued_run", 32'(busy), 32'd0);

    // Reset mid-run: abort, outputs cleared, no done.
    start_run(1500, 470, 1'b0);
    while (cyc < 20) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_total", 32'(preco_total), 32'd0);
    check("abort_preco", 32'(preco), 32'd0);
    check("abort_precof", 32'(precof), 32'd0);
    void'(exp_q.pop_back());
    hold_total = '0;
    repeat (3) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("idle_no_done", 32'(done), 32'd0);
    end
    start_run(123, 456, 1'b0);
    wait_done(53);

    start_run(0, 4095, 1'b0);
    wait_done(53);

    // Start held high: the edge right after done begins the next run.
    start_run(700, 300, 1'b1);
    weight = 12'd2500;
    cents  = 12'd80;
    push_exp(2500, 80);
    wait_done(53);
    start = 1'b0;
    cyc   = 0;
    check("held_restart_busy", 32'(busy), 32'd1);
    wait_done(53);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplicador.md
MULTIPLICADOR -- requirements
Module: multiplicador

Interface
REQ-001 Parameter GRAMS_PER_KG, default 1000: divisor that converts gram-cents to cents.
REQ-002 Parameter CENTS_PER_EURO, default 100: divisor that splits total cents into euros and cents.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: request pulse; sampled only while idle.
REQ-006 Port weightInGrams, input, 12: net weight in grams, unsigned, 0..4095.
REQ-007 Port centimos, input, 12: unit price in cents per kilogram, unsigned, 0..4095.
REQ-008 Port busy, output, 1: high while a computation is in progress.
REQ-009 Port done, output, 1: one-cycle pulse marking that result outputs were just updated.
REQ-010 Port preco, output, 12: whole-euro part of the price, zero-extended.
REQ-011 Port precof, output, 12: cents part of the price (0..99), zero-extended.
REQ-012 Port preco_total, output, 16: total price in cents.

Function
REQ-013 The block SHALL compute total = floor(weightInGrams * centimos / GRAMS_PER_KG), using truncation with no rounding.
REQ-014 It SHALL output preco = total / CENTS_PER_EURO and precof = total % CENTS_PER_EURO, with preco_total = total.
REQ-015 The product width SHALL be 24 bits; at the maximum input the product is 16 769 025 and total is 16 769, so no overflow path is needed.
REQ-016 The FSM SHALL have the states IDLE, MUL, DIV, SPLIT and FIN.
REQ-017 In IDLE with start=1 at a rising edge, the block SHALL latch both inputs, set busy=1 and go to MUL.
REQ-018 In MUL, the block SHALL perform a 12-iteration shift-add multiply, one partial product per cycle.
REQ-019 In DIV, the block SHALL perform a 24-iteration restoring division of the product by GRAMS_PER_KG, one quotient bit per cycle.
REQ-020 In SPLIT, the block SHALL perform a 16-iteration restoring division of total by CENTS_PER_EURO, one quotient bit per cycle.
REQ-021 In FIN, the block SHALL register preco, precof and preco_total, pulse done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-022 Latency SHALL be fixed: done is high in the cycle following the 53rd rising edge counted from the edge that accepted start, regardless of data values.
REQ-023 Result outputs SHALL hold their last values until the next FIN, and SHALL NOT change during MUL, DIV or SPLIT.
REQ-024 start asserted while busy=1 SHALL be ignored, with no queuing and no abort.
REQ-025 start held high continuously SHALL begin a new computation on the first edge after FIN, since IDLE is re-entered.
REQ-026 Input changes after the accepting edge SHALL NOT affect the result in progress.
REQ-027 Zero on either operand SHALL yield total=0, preco=0 and precof=0 with the same fixed latency.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously force state=IDLE, busy=0, done=0, preco=0, precof=0, preco_total=0 and clear all internal accumulators.
REQ-029 Reset asserted mid-computation SHALL abort it with no done pulse, and outputs SHALL read 0.
REQ-030 After rst_n deasserts, the first start SHALL be honoured on the first rising edge at which rst_n=1 and start=1.

Verification
REQ-031 The bench SHALL cover: weight 1500, centimos 470, start pulse -> total 705, preco 7, precof 5, single done pulse at the fixed latency.
REQ-032 The bench SHALL cover: weight 4095, centimos 4095 -> total 16769, preco 167, precof 69.
REQ-033 The bench SHALL cover: weight 1000, centimos 199 -> total 199, preco 1, precof 99; then weight 999, centimos 1 -> total 0, preco 0, precof 0 (truncation).
REQ-034 The bench SHALL cover: start again at 10 cycles into a run with different inputs -> ignored, and the first run's result appears unchanged.
REQ-035 The bench SHALL cover: rst_n pulled low at 20 cycles into a run -> outputs 0 immediately, no done, busy=0; a fresh start after release completes normally.
REQ-036 The bench SHALL cover: weight 0, centimos 4095 -> all results 0, done at the fixed latency.
